// File: rtl/boltzmann_pkg.sv
// rtl/boltzmann_pkg.sv - shared constants and output-register state type for the decimator path
// Contents: SAMPLE_W, MAX_LOG2, ACC_W and the holding-register state enum (EMPTY, FULL).
package boltzmann_pkg;

    localparam int SAMPLE_W = 16;
    localparam int MAX_LOG2 = 10;
    localparam int ACC_W    = SAMPLE_W + MAX_LOG2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/decim_out_reg.sv
// rtl/decim_out_reg.sv - one-deep valid/ready holding register with sticky overrun flag
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   load_i, din_i    : a new result is offered this cycle
//   data_o, valid_o  : held result and its valid flag
//   ready_i          : consumer takes data_o when valid_o && ready_i
//   overrun_o        : sticky, set when a result arrives while full and not drained
//   clr_ovr_i        : synchronous clear of overrun_o (a same-cycle overrun wins)
module decim_out_reg
    import boltzmann_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ready_i,
    input  logic             clr_ovr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    out_state_t state, state_nxt;
    logic       take;
    logic       drop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (load_i) begin
                    take      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (ready_i) begin
                    // Drain and refill in the same cycle so back-to-back results have no bubble.
                    if (load_i) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end else if (load_i) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else if (take) begin
            data_o <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_o <= 1'b0;
        end else if (drop) begin
            overrun_o <= 1'b1;
        end else if (clr_ovr_i) begin
            overrun_o <= 1'b0;
        end
    end

    assign valid_o = (state == FULL);

endmodule

// File: rtl/decim_avg.sv
// rtl/decim_avg.sv - block-averaging decimator: mean of 2^k valid samples per output
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   data_i, valid_i      : signed input sample stream
//   log2_n_i             : requested log2 block length, clamped to MAX_LOG2, latched at block start
//   data_o, valid_o      : signed block mean, held until ready_i
//   ready_i              : consumer handshake
//   overrun_o, clr_ovr_i : sticky dropped-result flag and its clear
// Build option: DECIM_ROUND_EN selects round-half-up instead of truncation toward -inf.
module decim_avg
    import boltzmann_pkg::*;
#(
    parameter int WIDTH    = SAMPLE_W,
    parameter int MAX_LOG2 = boltzmann_pkg::MAX_LOG2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic                    valid_i,
    input  logic [3:0]              log2_n_i,
    output logic signed [WIDTH-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overrun_o,
    input  logic                    clr_ovr_i
);

    // Wide enough to sum 2^MAX_LOG2 full-scale samples without overflow.
    localparam int ACC_BITS = WIDTH + MAX_LOG2;
    localparam logic [MAX_LOG2:0]   BLK_ONE = 1;
    localparam logic [MAX_LOG2-1:0] CNT_ONE = 1;

    logic [3:0]                 k_req;
    logic [3:0]                 k_reg;
    logic [3:0]                 k_cur;
    logic [MAX_LOG2-1:0]        cnt;
    logic [MAX_LOG2:0]          blk_last;
    logic                       last;
    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] sum;
    logic signed [ACC_BITS-1:0] sum_adj;
    logic signed [WIDTH-1:0]    result;

    assign k_req = (log2_n_i > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : log2_n_i;

    // The first sample of a block uses the live request; later samples use the latched k,
    // so a mid-block change of log2_n_i only affects the next block.
    assign k_cur    = (cnt == '0) ? k_req : k_reg;
    assign blk_last = (BLK_ONE << k_cur) - BLK_ONE;
    assign last     = valid_i && ({1'b0, cnt} == blk_last);
    assign sum      = acc + ACC_BITS'(data_i);

`ifdef DECIM_ROUND_EN
    localparam logic signed [ACC_BITS-1:0] ACC_ONE = 1;
    assign sum_adj = (k_cur == 4'd0) ? sum : sum + (ACC_ONE << (k_cur - 4'd1));
`else
    assign sum_adj = sum;
`endif

    // Arithmetic shift floors toward -inf; the mean always fits back into WIDTH bits.
    assign result = WIDTH'(sum_adj >>> k_cur);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc   <= '0;
            cnt   <= '0;
            k_reg <= '0;
        end else if (valid_i) begin
            if (cnt == '0) begin
                k_reg <= k_req;
            end
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    decim_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (last),
        .din_i    (result),
        .ready_i  (ready_i),
        .clr_ovr_i(clr_ovr_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .overrun_o(overrun_o)
    );

endmodule

// File: tb/tb_decim_avg.sv
// tb/tb_decim_avg.sv - self-checking bench for decim_avg (vector table, corner sequences, random vs model)
module tb_decim_avg;

    logic                clk = 1'b0;
    logic                rst_i;
    logic signed [15:0]  data_i;
    logic                valid_i;
    logic [3:0]          log2_n_i;
    logic signed [15:0]  data_o;
    logic                valid_o;
    logic                ready_i;
    logic                overrun_o;
    logic                clr_ovr_i;

    always #5 clk = ~clk;

    decim_avg #(
        .WIDTH   (16),
        .MAX_LOG2(10)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .log2_n_i (log2_n_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o),
        .clr_ovr_i(clr_ovr_i)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: a block is a list of samples; its mean is computed by floor division.
    int blk_q[$];
    int blk_k;
    int m_data;
    bit m_valid;
    bit m_ovr;

    typedef struct {
        bit v;
        int d;
        int l;
        bit r;
        bit c;
        bit ev;
        int ed;
        bit eo;
    } vec_t;

    function automatic int block_mean(input longint s_in, input int k);
        longint n;
        longint s;
        longint q;
        n = longint'(1) << k;
        s = s_in;
`ifdef DECIM_ROUND_EN
        if (k > 0) s = s + n / 2;
`endif
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return int'(q);
    endfunction

    task automatic model_reset();
        blk_q.delete();
        blk_k   = 0;
        m_data  = 0;
        m_valid = 0;
        m_ovr   = 0;
    endtask

    task automatic model_step();
        bit     have;
        bit     drop;
        int     res;
        longint s;
        have = 0;
        res  = 0;
        if (valid_i) begin
            if (blk_q.size() == 0) blk_k = (int'(log2_n_i) > 10) ? 10 : int'(log2_n_i);
            blk_q.push_back(int'(data_i));
            if (blk_q.size() == (1 << blk_k)) begin
                s = 0;
                foreach (blk_q[i]) s += blk_q[i];
                res  = block_mean(s, blk_k);
                have = 1;
                blk_q.delete();
            end
        end
        drop = have && m_valid && !ready_i;
        if (have) begin
            if (!m_valid || ready_i) begin
                m_data  = res;
                m_valid = 1;
            end
        end else if (m_valid && ready_i) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr_ovr_i) m_ovr = 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_data"}, int'(data_o), m_data);
        chk({tag, "_valid"}, int'(valid_o), int'(m_valid));
        chk({tag, "_ovr"}, int'(overrun_o), int'(m_ovr));
    endtask

    task automatic cycle(input bit v, input int d, input int l, input bit r, input bit c);
        valid_i   = v;
        data_i    = 16'(d);
        log2_n_i  = 4'(l);
        ready_i   = r;
        clr_ovr_i = c;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        data_i    = '0;
        log2_n_i  = '0;
        ready_i   = 1'b0;
        clr_ovr_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];
        int   neg_mean;
        bit   early;
        int   v, d, l, r, c;

`ifdef DECIM_ROUND_EN
        neg_mean = -1;
`else
        neg_mean = -2;
`endif
        // k=2 mean of 4,8,12,16
        tbl.push_back('{1, 4, 2, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 8, 2, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 12, 2, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 16, 2, 1, 0, 1, 10, 0});
        tbl.push_back('{0, 0, 2, 1, 0, 0, 10, 0});
        // k=1 negative and full-scale
        tbl.push_back('{1, -1, 1, 1, 0, 0, 10, 0});
        tbl.push_back('{1, -2, 1, 1, 0, 1, neg_mean, 0});
        tbl.push_back('{1, 32767, 1, 1, 0, 0, neg_mean, 0});
        tbl.push_back('{1, 32767, 1, 1, 0, 1, 32767, 0});
        // k=0 pass-through
        tbl.push_back('{1, 5, 0, 1, 0, 1, 5, 0});
        tbl.push_back('{1, -7, 0, 1, 0, 1, -7, 0});
        tbl.push_back('{1, 100, 0, 1, 0, 1, 100, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 100, 0});
        // k=1 stalled consumer, overrun, drain, clear
        tbl.push_back('{1, 2, 1, 0, 0, 0, 100, 0});
        tbl.push_back('{1, 4, 1, 0, 0, 1, 3, 0});
        tbl.push_back('{1, 6, 1, 0, 0, 1, 3, 0});
        tbl.push_back('{1, 8, 1, 0, 0, 1, 3, 1});
        tbl.push_back('{0, 0, 1, 1, 0, 0, 3, 1});
        tbl.push_back('{0, 0, 1, 0, 1, 0, 3, 0});

        rst_i = 1'b1;
        do_reset();
        chk("reset_data", int'(data_o), 0);
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_ovr", int'(overrun_o), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].c);
            chk($sformatf("vec%0d_data", i), int'(data_o), tbl[i].ed);
            chk($sformatf("vec%0d_valid", i), int'(valid_o), int'(tbl[i].ev));
            chk($sformatf("vec%0d_ovr", i), int'(overrun_o), int'(tbl[i].eo));
        end

        // Async reset mid-block discards the partial sum.
        cycle(1, 100, 2, 1, 0);
        cycle(1, 100, 2, 1, 0);
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        model_reset();
        chk("midrst_data", int'(data_o), 0);
        chk("midrst_valid", int'(valid_o), 0);
        chk("midrst_ovr", int'(overrun_o), 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 2, 1, 0);
        chk("midrst_res_valid", int'(valid_o), 1);
        chk("midrst_res_data", int'(data_o), 1);

        // log2_n_i=15 clamps to 1024 samples; a mid-block change is ignored.
        early = 0;
        for (int i = 0; i < 1024; i++) begin
            cycle(1, 3, (i < 512) ? 15 : 1, 1, 0);
            if (i < 1023 && valid_o) early = 1;
        end
        chk("clamp_early", int'(early), 0);
        chk("clamp_valid", int'(valid_o), 1);
        chk("clamp_data", int'(data_o), 3);
        cycle(0, 0, 1, 1, 0);
        chk("clamp_after_valid", int'(valid_o), 0);
        cycle(1, 9, 1, 1, 0);
        cycle(1, 9, 1, 1, 0);
        chk("next_blk_valid", int'(valid_o), 1);
        chk("next_blk_data", int'(data_o), 9);

        // Randomized traffic against the reference model.
        do_reset();
        chk_model("rnd_reset");
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 9) < 7) ? 1 : 0;
            case ($urandom_range(0, 7))
                0:       d = 32767;
                1:       d = -32768;
                default: d = int'($urandom_range(0, 65535)) - 32768;
            endcase
            l = ($urandom_range(0, 39) == 0) ? 15 : int'($urandom_range(0, 3));
            r = ($urandom_range(0, 9) < 6) ? 1 : 0;
            c = ($urandom_range(0, 19) == 0) ? 1 : 0;
            cycle(v[0], d, l, r[0], c[0]);
            chk_model($sformatf("rnd%0d", i));
            if (i == 1500) begin
                rst_i = 1'b1;
                #2;
                rst_i = 1'b0;
                model_reset();
                chk_model("rnd_midrst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
